// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//    Arbitrates an instruction port and a data port onto one single-port RAM.
//    Grants are combinational in the request cycle. The RAM answers one cycle
//    later, and the arbiter steers that answer back to the port that won.
//    Accesses outside the RAM window are still granted. They never reach the
//    RAM; instead they get an internally generated error response. The block
//    also keeps saturating grant and conflict statistics.
//
// Parameters:
//    MEM_SIZE  - RAM size in bytes (power of two)
//    MEM_START - RAM base byte address (MEM_SIZE aligned)
//    RR_EN     - 0: instruction port always wins a conflict
//                1: round-robin between the two ports on conflict
//
// Ports:
//    clk_sys, rst_sys            - clock, asynchronous active-high reset
//    instr_req_i/addr_i          - instruction request
//    instr_gnt/rvalid/err/rdata  - instruction grant and response
//    data_req/we/be/addr/wdata_i - data request
//    data_gnt/rvalid/err/rdata   - data grant and response
//    mem_req/we/be/addr/wdata_o  - request to the RAM
//    mem_rvalid_i, mem_rdata_i   - RAM response (one cycle after mem_req_o)
//    cnt_instr/data/conflict_o   - 16-bit saturating statistics
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int unsigned MEM_SIZE  = 32'd65536,
   parameter logic [31:0] MEM_START = 32'h0000_0000,
   parameter bit          RR_EN     = 1'b0
) (
   input  logic        clk_sys,
   input  logic        rst_sys,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic        instr_err_o,
   output logic [31:0] instr_rdata_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic        data_err_o,
   output logic [31:0] data_rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic [15:0] cnt_instr_o,
   output logic [15:0] cnt_data_o,
   output logic [15:0] cnt_conflict_o
);

   typedef enum logic {
      PORT_INSTR = 1'b0,
      PORT_DATA  = 1'b1
   } port_e;

   localparam logic [31:0] ADDR_MASK = ~(MEM_SIZE - 32'd1);

   // True when the byte address falls inside the RAM window.
   function automatic logic in_range(input logic [31:0] addr);
      return ((addr & ADDR_MASK) == MEM_START);
   endfunction

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : (value + 16'd1);
   endfunction

   port_e       last_q;
   logic        resp_v_q;
   port_e       owner_q;
   logic        err_q;
   logic        proto_err_q;
   logic [15:0] cnt_instr_q;
   logic [15:0] cnt_data_q;
   logic [15:0] cnt_conflict_q;

   logic        instr_win_s;
   logic        data_win_s;
   logic        win_err_s;

   // Winner selection. This uses only the live requests and last_q, so no
   // RAM response signal can reach a grant.
   always_comb begin
      instr_win_s = 1'b0;
      data_win_s  = 1'b0;
      if (rst_sys) begin
         instr_win_s = 1'b0;
      end else if (instr_req_i && data_req_i) begin
         // Round-robin hands a conflict to whichever port did not win last.
         if (RR_EN && (last_q == PORT_INSTR)) begin
            data_win_s = 1'b1;
         end else begin
            instr_win_s = 1'b1;
         end
      end else if (instr_req_i) begin
         instr_win_s = 1'b1;
      end else if (data_req_i) begin
         data_win_s = 1'b1;
      end else begin
         instr_win_s = 1'b0;
      end
   end

   // RAM request steering. Write controls come from the data port only.
   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'b0000;
      mem_addr_o  = 32'h0000_0000;
      mem_wdata_o = 32'h0000_0000;
      win_err_s   = 1'b0;
      if (instr_win_s) begin
         if (in_range(instr_addr_i)) begin
            mem_req_o  = 1'b1;
            mem_addr_o = instr_addr_i;
         end else begin
            win_err_s = 1'b1;
         end
      end else if (data_win_s) begin
         if (in_range(data_addr_i)) begin
            mem_req_o   = 1'b1;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
         end else begin
            win_err_s = 1'b1;
         end
      end else begin
         win_err_s = 1'b0;
      end
   end

   assign instr_gnt_o = instr_win_s;
   assign data_gnt_o  = data_win_s;

   // Response stage: remembers who was granted and whether the access missed
   // the RAM. Reset drops any pending response.
   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         resp_v_q <= 1'b0;
         owner_q  <= PORT_DATA;
         err_q    <= 1'b0;
         last_q   <= PORT_DATA;
      end else if (instr_win_s || data_win_s) begin
         resp_v_q <= 1'b1;
         owner_q  <= data_win_s ? PORT_DATA : PORT_INSTR;
         err_q    <= win_err_s;
         last_q   <= data_win_s ? PORT_DATA : PORT_INSTR;
      end else begin
         resp_v_q <= 1'b0;
      end
   end

   // Sticky flag: the RAM failed to answer an in-range access on time.
   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         proto_err_q <= 1'b0;
      end else if (resp_v_q && !err_q && !mem_rvalid_i) begin
         proto_err_q <= 1'b1;
      end
   end

   // Response routing. The response is driven even if the RAM did not assert
   // mem_rvalid_i, so the requester never stalls.
   always_comb begin
      instr_rvalid_o = 1'b0;
      instr_err_o    = 1'b0;
      instr_rdata_o  = 32'h0000_0000;
      data_rvalid_o  = 1'b0;
      data_err_o     = 1'b0;
      data_rdata_o   = 32'h0000_0000;
      if (resp_v_q && !rst_sys) begin
         if (owner_q == PORT_DATA) begin
            data_rvalid_o = 1'b1;
            data_err_o    = err_q;
            data_rdata_o  = err_q ? 32'h0000_0000 : mem_rdata_i;
         end else begin
            instr_rvalid_o = 1'b1;
            instr_err_o    = err_q;
            instr_rdata_o  = err_q ? 32'h0000_0000 : mem_rdata_i;
         end
      end else begin
         data_rvalid_o = 1'b0;
      end
   end

   // Saturating grant and conflict statistics.
   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         cnt_instr_q    <= 16'h0000;
         cnt_data_q     <= 16'h0000;
         cnt_conflict_q <= 16'h0000;
      end else begin
         if (instr_win_s) begin
            cnt_instr_q <= sat_inc(cnt_instr_q);
         end
         if (data_win_s) begin
            cnt_data_q <= sat_inc(cnt_data_q);
         end
         if (instr_req_i && data_req_i) begin
            cnt_conflict_q <= sat_inc(cnt_conflict_q);
         end
      end
   end

   assign cnt_instr_o    = cnt_instr_q;
   assign cnt_data_o     = cnt_data_q;
   assign cnt_conflict_o = cnt_conflict_q;

   mem_arbiter_chk u_chk (
      .clk_sys   (clk_sys),
      .rst_sys   (rst_sys),
      .instr_gnt (instr_win_s),
      .data_gnt  (data_win_s),
      .proto_err (proto_err_q)
   );

endmodule

// -----------------------------------------------------------------------------
// mem_arbiter_chk
//
// Purpose: runtime checks for mem_arbiter. It checks that the two grants are
//          never high together and that the protocol error flag never clears
//          outside reset.
// Ports:   clk_sys, rst_sys, the two grants, and the sticky protocol flag.
// -----------------------------------------------------------------------------
module mem_arbiter_chk (
   input logic clk_sys,
   input logic rst_sys,
   input logic instr_gnt,
   input logic data_gnt,
   input logic proto_err
);

   a_one_grant : assert property (@(posedge clk_sys) disable iff (rst_sys)
                                  !(instr_gnt && data_gnt));

   a_proto_sticky : assert property (@(posedge clk_sys) disable iff (rst_sys)
                                     $past(proto_err) |-> proto_err);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Testbench for mem_arbiter. Two instances share all inputs:
//    dut0 - fixed instruction priority (RR_EN = 0)
//    dut1 - round-robin (RR_EN = 1)
// A transaction-level reference model tracks both instances. Directed vectors
// and hand-written sequences cover the named scenarios, and a random phase
// exercises the rest.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   logic        clk_sys = 1'b0;
   logic        rst_sys;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic        data_req, data_we;
   logic [3:0]  data_be;
   logic [31:0] data_addr, data_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   logic        ig[2], irv[2], ierr[2], dg[2], drv[2], derr[2];
   logic [31:0] ird[2], drd[2];
   logic        mreq[2], mwe[2];
   logic [3:0]  mbe[2];
   logic [31:0] maddr[2], mwd[2];
   logic [15:0] ci[2], cd[2], cc[2];

   int n_tests = 0;
   int n_fail  = 0;
   bit do_chk  = 1'b1;

   // Reference model state, one copy per instance (0 = fixed, 1 = round-robin).
   // Port ids: 1 = instruction, 2 = data.
   int m_last[2];
   bit m_rv[2];
   int m_own[2];
   bit m_err[2];
   int m_ci[2], m_cd[2], m_cc[2];

   always #5 clk_sys = ~clk_sys;

   mem_arbiter #(.MEM_SIZE(65536), .MEM_START(32'h0), .RR_EN(1'b0)) dut0 (
      .clk_sys(clk_sys), .rst_sys(rst_sys),
      .instr_req_i(instr_req), .instr_addr_i(instr_addr),
      .instr_gnt_o(ig[0]), .instr_rvalid_o(irv[0]), .instr_err_o(ierr[0]), .instr_rdata_o(ird[0]),
      .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
      .data_addr_i(data_addr), .data_wdata_i(data_wdata),
      .data_gnt_o(dg[0]), .data_rvalid_o(drv[0]), .data_err_o(derr[0]), .data_rdata_o(drd[0]),
      .mem_req_o(mreq[0]), .mem_we_o(mwe[0]), .mem_be_o(mbe[0]), .mem_addr_o(maddr[0]),
      .mem_wdata_o(mwd[0]), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
      .cnt_instr_o(ci[0]), .cnt_data_o(cd[0]), .cnt_conflict_o(cc[0]));

   mem_arbiter #(.MEM_SIZE(65536), .MEM_START(32'h0), .RR_EN(1'b1)) dut1 (
      .clk_sys(clk_sys), .rst_sys(rst_sys),
      .instr_req_i(instr_req), .instr_addr_i(instr_addr),
      .instr_gnt_o(ig[1]), .instr_rvalid_o(irv[1]), .instr_err_o(ierr[1]), .instr_rdata_o(ird[1]),
      .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
      .data_addr_i(data_addr), .data_wdata_i(data_wdata),
      .data_gnt_o(dg[1]), .data_rvalid_o(drv[1]), .data_err_o(derr[1]), .data_rdata_o(drd[1]),
      .mem_req_o(mreq[1]), .mem_we_o(mwe[1]), .mem_be_o(mbe[1]), .mem_addr_o(maddr[1]),
      .mem_wdata_o(mwd[1]), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
      .cnt_instr_o(ci[1]), .cnt_data_o(cd[1]), .cnt_conflict_o(cc[1]));

   typedef struct {
      logic        ireq;  logic [31:0] iaddr;
      logic        dreq;  logic dwe; logic [3:0] dbe; logic [31:0] daddr; logic [31:0] dwd;
      logic        mrv;   logic [31:0] mrd;
      logic        e_ig;  logic e_dg; logic e_mreq; logic e_mwe; logic [3:0] e_mbe; logic [31:0] e_maddr;
      logic        e_irv; logic e_ierr; logic [31:0] e_ird;
      logic        e_drv; logic e_derr; logic [31:0] e_drd;
      logic [15:0] e_ci;  logic [15:0] e_cd;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit in_window(input logic [31:0] addr);
      return (addr < 32'd65536);
   endfunction

   function automatic int sat16(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   // Compare both instances against the model, then advance the model and the
   // clock. Inputs were set just after the falling edge; sampling is mid-phase.
   task automatic cycle();
      int win;
      logic [31:0] waddr;
      #1;
      for (int k = 0; k < 2; k++) begin
         if (rst_sys) begin
            m_last[k] = 2; m_rv[k] = 1'b0; m_err[k] = 1'b0;
            m_ci[k] = 0; m_cd[k] = 0; m_cc[k] = 0;
         end
         win = 0;
         if (!rst_sys) begin
            if (instr_req && data_req) win = (k == 1 && m_last[k] == 1) ? 2 : 1;
            else if (instr_req) win = 1;
            else if (data_req) win = 2;
         end
         waddr = (win == 1) ? instr_addr : data_addr;
         if (do_chk) begin
            chk($sformatf("igNT%0d", k), ig[k], win == 1);
            chk($sformatf("dgnt%0d", k), dg[k], win == 2);
            chk($sformatf("mreq%0d", k), mreq[k], win != 0 && in_window(waddr));
            chk($sformatf("maddr%0d", k), maddr[k], (win != 0 && in_window(waddr)) ? waddr : 32'h0);
            chk($sformatf("mwe%0d", k), mwe[k], win == 2 && in_window(waddr) && data_we);
            chk($sformatf("mbe%0d", k), mbe[k], (win == 2 && in_window(waddr)) ? data_be : 4'h0);
            chk($sformatf("mwd%0d", k), mwd[k], (win == 2 && in_window(waddr)) ? data_wdata : 32'h0);
            chk($sformatf("irv%0d", k), irv[k], m_rv[k] && m_own[k] == 1);
            chk($sformatf("ierr%0d", k), ierr[k], m_rv[k] && m_own[k] == 1 && m_err[k]);
            chk($sformatf("ird%0d", k), ird[k], (m_rv[k] && m_own[k] == 1 && !m_err[k]) ? mem_rdata : 32'h0);
            chk($sformatf("drv%0d", k), drv[k], m_rv[k] && m_own[k] == 2);
            chk($sformatf("derr%0d", k), derr[k], m_rv[k] && m_own[k] == 2 && m_err[k]);
            chk($sformatf("drd%0d", k), drd[k], (m_rv[k] && m_own[k] == 2 && !m_err[k]) ? mem_rdata : 32'h0);
            chk($sformatf("cnt_instr%0d", k), ci[k], m_ci[k]);
            chk($sformatf("cnt_data%0d", k), cd[k], m_cd[k]);
            chk($sformatf("cnt_conf%0d", k), cc[k], m_cc[k]);
         end
         if (!rst_sys) begin
            m_rv[k] = (win != 0);
            if (win != 0) begin
               m_own[k] = win; m_last[k] = win; m_err[k] = !in_window(waddr);
            end
            if (win == 1) m_ci[k] = sat16(m_ci[k] + 1);
            if (win == 2) m_cd[k] = sat16(m_cd[k] + 1);
            if (instr_req && data_req) m_cc[k] = sat16(m_cc[k] + 1);
         end
      end
      @(posedge clk_sys);
      @(negedge clk_sys);
   endtask

   task automatic idle();
      instr_req = 1'b0; instr_addr = 32'h0;
      data_req = 1'b0; data_we = 1'b0; data_be = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
      mem_rvalid = 1'b1; mem_rdata = 32'h0;
   endtask

   task automatic do_reset();
      idle();
      rst_sys = 1'b1;
      cycle();
      rst_sys = 1'b0;
   endtask

   vec_t vecs[8];

   initial begin
      rst_sys = 1'b1;
      idle();
      @(negedge clk_sys);

      // Outputs must stay forced low during reset even with requests present.
      instr_req = 1'b1; data_req = 1'b1; data_addr = 32'h40;
      cycle();
      do_reset();

      // Directed vectors against the fixed-priority instance.
      vecs[0] = '{1, 32'h80, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0,
                  1, 0, 1, 0, 4'h0, 32'h80, 0, 0, 32'h0, 0, 0, 32'h0, 16'd0, 16'd0};
      vecs[1] = '{0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h13,
                  0, 0, 0, 0, 4'h0, 32'h0, 1, 0, 32'h13, 0, 0, 32'h0, 16'd1, 16'd0};
      vecs[2] = '{0, 32'h0, 1, 1, 4'b0011, 32'h100, 32'hDEADBEEF, 1, 32'h0,
                  0, 1, 1, 1, 4'b0011, 32'h100, 0, 0, 32'h0, 0, 0, 32'h0, 16'd1, 16'd0};
      vecs[3] = '{0, 32'h0, 1, 0, 4'hF, 32'h100, 32'h0, 1, 32'h0,
                  0, 1, 1, 0, 4'hF, 32'h100, 0, 0, 32'h0, 1, 0, 32'h0, 16'd1, 16'd1};
      vecs[4] = '{0, 32'h0, 1, 0, 4'hF, 32'h0001_0000, 32'h0, 1, 32'h0000BEEF,
                  0, 1, 0, 0, 4'h0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0000BEEF, 16'd1, 16'd2};
      vecs[5] = '{0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h12345678,
                  0, 0, 0, 0, 4'h0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h0, 16'd1, 16'd3};
      vecs[6] = '{1, 32'hFFFF_0000, 1, 0, 4'hF, 32'h200, 32'h0, 1, 32'h0,
                  1, 0, 0, 0, 4'h0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 16'd1, 16'd3};
      vecs[7] = '{0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h55,
                  0, 0, 0, 0, 4'h0, 32'h0, 1, 1, 32'h0, 0, 0, 32'h0, 16'd2, 16'd3};
      for (int i = 0; i < 8; i++) begin
         instr_req = vecs[i].ireq; instr_addr = vecs[i].iaddr;
         data_req = vecs[i].dreq; data_we = vecs[i].dwe; data_be = vecs[i].dbe;
         data_addr = vecs[i].daddr; data_wdata = vecs[i].dwd;
         mem_rvalid = vecs[i].mrv; mem_rdata = vecs[i].mrd;
         #1;
         chk($sformatf("v%0d_ignt", i), ig[0], vecs[i].e_ig);
         chk($sformatf("v%0d_dgnt", i), dg[0], vecs[i].e_dg);
         chk($sformatf("v%0d_mreq", i), mreq[0], vecs[i].e_mreq);
         chk($sformatf("v%0d_mwe", i), mwe[0], vecs[i].e_mwe);
         chk($sformatf("v%0d_mbe", i), mbe[0], vecs[i].e_mbe);
         chk($sformatf("v%0d_maddr", i), maddr[0], vecs[i].e_maddr);
         chk($sformatf("v%0d_irv", i), irv[0], vecs[i].e_irv);
         chk($sformatf("v%0d_ierr", i), ierr[0], vecs[i].e_ierr);
         chk($sformatf("v%0d_ird", i), ird[0], vecs[i].e_ird);
         chk($sformatf("v%0d_drv", i), drv[0], vecs[i].e_drv);
         chk($sformatf("v%0d_derr", i), derr[0], vecs[i].e_derr);
         chk($sformatf("v%0d_drd", i), drd[0], vecs[i].e_drd);
         chk($sformatf("v%0d_cnt_i", i), ci[0], vecs[i].e_ci);
         chk($sformatf("v%0d_cnt_d", i), cd[0], vecs[i].e_cd);
         cycle();
      end

      // Fixed-priority conflict for three cycles.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         instr_req = 1'b1; instr_addr = 32'h10; data_req = 1'b1; data_addr = 32'h20;
         #1;
         chk("fix_ignt", ig[0], 1'b1);
         chk("fix_dgnt", dg[0], 1'b0);
         cycle();
      end
      idle();
      #1;
      chk("fix_cnt_conf", cc[0], 16'd3);
      chk("fix_cnt_data", cd[0], 16'd0);
      cycle();

      // Round-robin alternation after reset: I, D, I, D.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         instr_req = 1'b1; instr_addr = 32'h10; data_req = 1'b1; data_addr = 32'h20;
         #1;
         chk($sformatf("rr_ignt%0d", i), ig[1], (i % 2) == 0);
         chk($sformatf("rr_dgnt%0d", i), dg[1], (i % 2) == 1);
         cycle();
      end
      idle();
      #1;
      chk("rr_cnt_instr", ci[1], 16'd2);
      chk("rr_cnt_data", cd[1], 16'd2);
      cycle();

      // Reset in the cycle after a grant: the response is dropped.
      idle();
      data_req = 1'b1; data_addr = 32'h300;
      cycle();
      idle();
      rst_sys = 1'b1;
      #1;
      chk("rst_drv", drv[0], 1'b0);
      cycle();
      rst_sys = 1'b0;
      #1;
      chk("rst_post_drv", drv[0], 1'b0);
      chk("rst_post_cnt_d", cd[0], 16'd0);
      chk("rst_post_cnt_c", cc[0], 16'd0);
      cycle();

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         rst_sys    = ($urandom_range(0, 59) == 0);
         instr_req  = 1'($urandom_range(0, 1));
         data_req   = 1'($urandom_range(0, 1));
         instr_addr = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
         data_addr  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_FFFF);
         data_we    = 1'($urandom_range(0, 1));
         data_be    = 4'($urandom);
         data_wdata = $urandom;
         mem_rvalid = ($urandom_range(0, 9) != 0);
         mem_rdata  = $urandom;
         cycle();
      end

      // Data counter saturation.
      rst_sys = 1'b0;
      do_reset();
      do_chk = 1'b0;
      for (int i = 0; i < 65534; i++) begin
         idle();
         data_req = 1'b1; data_addr = 32'h400;
         cycle();
      end
      do_chk = 1'b1;
      #1;
      chk("sat_pre", cd[0], 16'hFFFE);
      for (int i = 0; i < 3; i++) begin
         idle();
         data_req = 1'b1; data_addr = 32'h400;
         cycle();
      end
      idle();
      #1;
      chk("sat_hold", cd[0], 16'hFFFF);
      cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
